// File: rtl/hard_disk_ctrl.sv
// hard_disk_ctrl: track/sector disk model with head seek timing and single-ported word storage.
module hard_disk_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int HD_TRILHAS_BITS = 4,
    parameter int HD_SETORES_BITS = 4,
    parameter int SEEK_CYCLES     = 2,
    parameter int ACCESS_CYCLES   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [HD_TRILHAS_BITS-1:0] trilha,
    input  logic [HD_SETORES_BITS-1:0] setor,
    input  logic [DATA_WIDTH-1:0]      data,
    input  logic                       hdWrite,
    input  logic                       hdRead,
    output logic [DATA_WIDTH-1:0]      dataOut,
    output logic                       busy,
    output logic                       done,
    output logic [HD_TRILHAS_BITS-1:0] trilhaAtual
);
    localparam int SW    = $clog2(SEEK_CYCLES + 1);
    localparam int AW    = $clog2(ACCESS_CYCLES + 1);
    localparam int ABITS = HD_TRILHAS_BITS + HD_SETORES_BITS;
    localparam int DEPTH = 2 ** ABITS;

    typedef enum logic [1:0] {IDLE, SEEK, ACCESS} state_t;

    state_t                     r_state, w_state_nxt;
    logic [HD_TRILHAS_BITS-1:0] r_trk, r_head, w_trk_nxt;
    logic [HD_SETORES_BITS-1:0] r_sec;
    logic [DATA_WIDTH-1:0]      r_data, r_dout;
    logic                       r_wr, r_done;
    logic [SW-1:0]              r_seek_cnt;
    logic [AW-1:0]              r_acc_cnt;
    logic                       w_accept, w_step, w_acc_last;
    logic [ABITS-1:0]           w_addr;
    // Storage starts zeroed and is deliberately outside the reset domain
    logic [DATA_WIDTH-1:0]      r_mem [0:DEPTH-1] = '{default: '0};

    assign w_addr      = {r_trk, r_sec};
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign dataOut     = r_dout;
    assign trilhaAtual = r_head;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_acc_last  = 1'b0;
        w_trk_nxt   = (r_trk > r_head) ? r_head + 1'b1 : r_head - 1'b1;
        case (r_state)
            IDLE: begin
                if (hdWrite || hdRead) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (trilha == r_head) ? ACCESS : SEEK;
                end
            end
            SEEK: begin
                if (r_seek_cnt == SW'(SEEK_CYCLES - 1)) begin
                    w_step = 1'b1;
                    if (w_trk_nxt == r_trk) w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (r_acc_cnt == AW'(ACCESS_CYCLES - 1)) begin
                    w_acc_last  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_trk      <= '0;
            r_sec      <= '0;
            r_data     <= '0;
            r_wr       <= 1'b0;
            r_seek_cnt <= '0;
            r_acc_cnt  <= '0;
            r_head     <= '0;
            r_dout     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_acc_last;
            r_seek_cnt <= (r_state == SEEK && !w_step) ? r_seek_cnt + 1'b1 : '0;
            r_acc_cnt  <= (r_state == ACCESS && !w_acc_last) ? r_acc_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_trk  <= trilha;
                r_sec  <= setor;
                r_data <= data;
                r_wr   <= hdWrite;
            end
            if (w_step) r_head <= w_trk_nxt;
            if (w_acc_last && !r_wr) r_dout <= r_mem[w_addr];
        end
    end

    // Reset forces IDLE asynchronously, so an aborted write never reaches this port
    always_ff @(posedge clock) begin
        if (w_acc_last && r_wr) r_mem[w_addr] <= r_data;
    end
endmodule

// File: doc/hard_disk_ctrl.md
HARD_DISK_CTRL -- requirements
Module: hard_disk_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits.
REQ-002 Parameter HD_TRILHAS_BITS, default 4: track address width; track count is 2**HD_TRILHAS_BITS.
REQ-003 Parameter HD_SETORES_BITS, default 4: sector address width; sectors per track is 2**HD_SETORES_BITS.
REQ-004 Parameter SEEK_CYCLES, default 2 (>=1): clock cycles per one-track head move.
REQ-005 Parameter ACCESS_CYCLES, default 1 (>=1): clock cycles for the sector access after the seek.
REQ-006 clock  in  1  single clock; all state updates on posedge.
REQ-007 reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-008 trilha  in  HD_TRILHAS_BITS  target track, sampled at acceptance.
REQ-009 setor  in  HD_SETORES_BITS  target sector, sampled at acceptance.
REQ-010 data  in  DATA_WIDTH  write data, sampled at acceptance.
REQ-011 hdWrite  in  1  write request, level, considered only when idle.
REQ-012 hdRead  in  1  read request, level, considered only when idle.
REQ-013 dataOut  out  DATA_WIDTH  registered result of the last completed read.
REQ-014 busy  out  1  high while a request is in progress.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 trilhaAtual  out  HD_TRILHAS_BITS  current head track.

Function
REQ-017 Storage SHALL be 2**HD_TRILHAS_BITS x 2**HD_SETORES_BITS words of DATA_WIDTH bits, zero-initialised at simulation start, single-ported.
REQ-018 FSM states SHALL be IDLE, SEEK, ACCESS; busy = (state != IDLE).
REQ-019 In IDLE, a posedge with hdWrite=1 or hdRead=1 SHALL accept: latch trilha, setor, data, op; hdWrite wins if both high.
REQ-020 On acceptance: if trilha == trilhaAtual, go to ACCESS; else go to SEEK.
REQ-021 In SEEK, trilhaAtual SHALL step by +1 or -1 toward the target every SEEK_CYCLES cycles, with no wrap-around; when it equals the target, go to ACCESS.
REQ-022 ACCESS SHALL last ACCESS_CYCLES cycles; on its final edge a write stores the latched data, or a read loads dataOut from the addressed word.
REQ-023 On that same edge the state SHALL return to IDLE and done SHALL be 1 for exactly one cycle.
REQ-024 Latency from the acceptance edge to the done-high edge SHALL be |target - trilhaAtual| * SEEK_CYCLES + ACCESS_CYCLES edges.
REQ-025 hdRead and hdWrite SHALL be ignored while busy; a request held high during the done cycle SHALL be accepted at that edge.
REQ-026 dataOut SHALL hold its value between reads and SHALL be unchanged by writes.
REQ-027 A read of a word written by the immediately preceding request SHALL return the new data.

Reset
REQ-028 While reset=0: state=IDLE, busy=0, done=0, dataOut=0, trilhaAtual=0, seek and access counters=0, request latches cleared.
REQ-029 Reset SHALL NOT clear storage contents; reset during SEEK or ACCESS SHALL abort the request, and an aborted write SHALL leave its target word unmodified.
REQ-030 The first acceptance SHALL occur no earlier than the first posedge after reset deasserts.

Verification (defaults: SEEK_CYCLES=2, ACCESS_CYCLES=1)
REQ-031 Reset, then hdRead with (0,0) -> busy high 1 cycle; done at accept+1; dataOut=0; trilhaAtual=0.
REQ-032 hdWrite 32'hDEADBEEF to (5,3) from head 0 -> trilhaAtual steps 1..5 every 2 cycles; done at accept+11. Then hdRead (5,3) -> done at accept+1; dataOut=32'hDEADBEEF.
REQ-033 From head 5, hdRead (2,3) -> trilhaAtual 4,3,2 decreasing; done at accept+7; dataOut=0.
REQ-034 hdRead and hdWrite both high for (1,1), data 32'h12345678, then pulse requests while busy -> treated as a write only; busy-time pulses ignored; a later read of (1,1) returns 32'h12345678.
REQ-035 Reset asserted mid-seek during a write to (9,0) -> outputs return immediately to REQ-028 values; a later read of (9,0) returns its prior content.
REQ-036 From head 15, hdRead (0,0) -> head moves down through 14..0 with no wrap; done at accept+31.
